// File: rtl/psum_drain_ctrl.sv
// Sequencer for an N x N output-stationary PE array: runs the
// accumulate phase, then drains partial sums one row per handshake.
module psum_drain_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int N          = 4,
   parameter int KW         = 8,
   localparam int PW        = 2 * DATA_WIDTH,
   localparam int RW        = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [KW-1:0]     k_len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              feed_en,
   output logic              set_reg,
   output logic              sel_mux,
   input  logic [N*PW-1:0]   psum_row,
   output logic [N*PW-1:0]   out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [RW-1:0]     out_row
);

   localparam int CW = KW + $clog2(2 * N) + 1;

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DRAIN,
      FLUSH
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] last;
   logic [KW-1:0] k_q;
   logic          comp_set;
   logic          fire;

   assign last     = CW'(k_q) + CW'(2 * N - 2);
   assign fire     = out_valid & out_ready;
   assign set_reg  = comp_set | fire;
   assign out_data = out_valid ? psum_row : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         k_q       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         feed_en   <= 1'b0;
         comp_set  <= 1'b0;
         sel_mux   <= 1'b0;
         out_valid <= 1'b0;
         out_row   <= RW'(N - 1);
      end else begin
         done <= 1'b0;
         if ((state == COMPUTE || state == DRAIN) && abort) begin
            // a fire on this edge still shifts; row index restored on exit
            if (fire) out_row <= out_row - RW'(1);
            state     <= FLUSH;
            cnt       <= '0;
            feed_en   <= 1'b0;
            comp_set  <= 1'b1;
            sel_mux   <= 1'b1;
            out_valid <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     k_q  <= k_len;
                     cnt  <= '0;
                     busy <= 1'b1;
                     if (k_len != '0) begin
                        state    <= COMPUTE;
                        feed_en  <= 1'b1;
                        comp_set <= 1'b1;
                     end else begin
                        state     <= DRAIN;
                        out_valid <= 1'b1;
                        sel_mux   <= 1'b1;
                     end
                  end
               end
               COMPUTE: begin
                  if (cnt == last) begin
                     state     <= DRAIN;
                     feed_en   <= 1'b0;
                     comp_set  <= 1'b0;
                     out_valid <= 1'b1;
                     sel_mux   <= 1'b1;
                  end else begin
                     cnt     <= cnt + CW'(1);
                     feed_en <= (cnt + CW'(1)) < CW'(k_q);
                  end
               end
               DRAIN: begin
                  if (fire) begin
                     if (out_row == '0) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        sel_mux   <= 1'b0;
                        out_row   <= RW'(N - 1);
                     end else begin
                        out_row <= out_row - RW'(1);
                     end
                  end
               end
               FLUSH: begin
                  if (cnt == CW'(N - 1)) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     comp_set <= 1'b0;
                     sel_mux  <= 1'b0;
                     out_row  <= RW'(N - 1);
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Bench for psum_drain_ctrl: behavioural skewed PE array around the DUT,
// drained rows compared against a queue of matrix-product rows.
module tb_psum_drain_ctrl;

   localparam int DW   = 8;
   localparam int N    = 4;
   localparam int KW   = 8;
   localparam int PW   = 2 * DW;
   localparam int RW   = 2;
   localparam int KMAX = 16;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [KW-1:0]   k_len;
   logic            abort;
   logic            busy;
   logic            done;
   logic            feed_en;
   logic            set_reg;
   logic            sel_mux;
   logic [N*PW-1:0] psum_row;
   logic [N*PW-1:0] out_data;
   logic            out_valid;
   logic            out_ready;
   logic [RW-1:0]   out_row;

   psum_drain_ctrl #(.DATA_WIDTH(DW), .N(N), .KW(KW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
      .abort(abort), .busy(busy), .done(done), .feed_en(feed_en),
      .set_reg(set_reg), .sel_mux(sel_mux), .psum_row(psum_row),
      .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_row(out_row)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] A [N][KMAX];
   logic [DW-1:0] B [KMAX][N];
   logic [DW-1:0] da [N][N];
   logic [DW-1:0] db [N][N];
   logic [DW-1:0] ah [N][N];
   logic [DW-1:0] bv [N][N];
   logic [PW-1:0] ps [N][N];
   logic [DW-1:0] fa [N];
   logic [DW-1:0] fb [N];
   logic [DW-1:0] ae [N];
   logic [DW-1:0] be [N];
   int            kidx;

   always_comb begin
      for (int r = 0; r < N; r++) begin
         fa[r] = feed_en ? A[r][kidx] : '0;
         fb[r] = feed_en ? B[kidx][r] : '0;
      end
      for (int r = 0; r < N; r++) begin
         ae[r] = (r == 0) ? fa[0] : da[r][r-1];
         be[r] = (r == 0) ? fb[0] : db[r][r-1];
      end
      psum_row = '0;
      for (int j = 0; j < N; j++) psum_row[j*PW +: PW] = ps[N-1][j];
   end

   // Skew feeders and PE array model
   always @(posedge clk or negedge rst_n) begin
      logic [DW-1:0] ain;
      logic [DW-1:0] bin;
      if (!rst_n) begin
         kidx <= 0;
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               da[r][c] <= '0; db[r][c] <= '0;
               ah[r][c] <= '0; bv[r][c] <= '0;
               ps[r][c] <= '0;
            end
      end else begin
         kidx <= !busy ? 0 : kidx + (feed_en ? 1 : 0);
         for (int r = 0; r < N; r++)
            for (int i = 0; i < N; i++) begin
               da[r][i] <= (i == 0) ? fa[r] : da[r][i-1];
               db[r][i] <= (i == 0) ? fb[r] : db[r][i-1];
            end
         if (set_reg) begin
            for (int r = 0; r < N; r++)
               for (int c = 0; c < N; c++) begin
                  if (sel_mux) begin
                     ps[r][c] <= (r == 0) ? '0 : ps[r-1][c];
                     ah[r][c] <= '0;
                     bv[r][c] <= '0;
                  end else begin
                     ain = (c == 0) ? ae[r] : ah[r][c-1];
                     bin = (r == 0) ? be[c] : bv[r-1][c];
                     ah[r][c] <= ain;
                     bv[r][c] <= bin;
                     ps[r][c] <= ps[r][c] + PW'(ain) * PW'(bin);
                  end
               end
         end
      end
   end

   typedef struct {
      logic [RW-1:0]   row;
      logic [N*PW-1:0] data;
   } exp_t;

   exp_t q[$];
   int   passed = 0;
   int   failed = 0;
   int   total  = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_rand(input int k);
      for (int r = 0; r < N; r++)
         for (int kk = 0; kk < k; kk++) begin
            A[r][kk] = DW'($urandom_range(0, 15));
            B[kk][r] = DW'($urandom_range(0, 15));
         end
   endtask

   task automatic push_expected(input int k);
      exp_t          e;
      logic [PW-1:0] s;
      for (int r = N - 1; r >= 0; r--) begin
         e.row  = RW'(r);
         e.data = '0;
         for (int c = 0; c < N; c++) begin
            s = '0;
            for (int kk = 0; kk < k; kk++)
               s = s + PW'(A[r][kk]) * PW'(B[kk][c]);
            e.data[c*PW +: PW] = s;
         end
         q.push_back(e);
      end
   endtask

   task automatic run_job(input int k, input logic [6:0] pat,
                          input int plen, input int abort_at,
                          input bit both);
      int cc = 0, fc = 0, fl = 0, g = 0, fires = 0, d = 0;
      if (abort_at < 0) push_expected(k);
      start = 1'b1; k_len = KW'(k); abort = both;
      step();
      start = 1'b0; abort = 1'b0;
      while (busy && !sel_mux && g < 600) begin
         check("compute_set", set_reg, 1);
         cc++;
         if (feed_en) fc++;
         if (cc == 2) begin start = 1'b1; k_len = '0; end
         if (cc == abort_at) abort = 1'b1;
         step();
         start = 1'b0; abort = 1'b0; g++;
      end
      if (abort_at >= 0) begin
         check("abort_cycle", cc, abort_at);
         while (busy && g < 600) begin
            check("flush_set", set_reg, 1);
            check("flush_sel", sel_mux, 1);
            check("flush_valid", out_valid, 0);
            check("flush_feed", feed_en, 0);
            check("flush_done", done, 0);
            fl++;
            step();
            g++;
         end
         check("flush_len", fl, N);
         check("flush_no_done", done, 0);
         return;
      end
      check("compute_len", cc, (k == 0) ? 0 : k + 2 * N - 1);
      check("feed_len", fc, k);
      while (busy && g < 600) begin
         out_ready = (d < plen) ? pat[d] : 1'b1;
         start = (d == 1);
         #1;
         check("drain_valid", out_valid, 1);
         check("drain_sel", sel_mux, 1);
         check("drain_set", set_reg, out_ready);
         if (q.size() > 0) begin
            check("drain_row", out_row, q[0].row);
            check("drain_data", out_data, q[0].data);
         end
         if (out_ready) begin
            fires++;
            if (q.size() > 0) void'(q.pop_front());
         end
         step();
         start = 1'b0; d++; g++;
      end
      out_ready = 1'b0;
      check("drain_fires", fires, N);
      check("done_pulse", done, 1);
      check("queue_empty", q.size(), 0);
      step();
      check("done_low", done, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      int g;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      k_len = '0; out_ready = 1'b0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_feed", feed_en, 0);
      check("rst_set", set_reg, 0);
      check("rst_sel", sel_mux, 0);
      check("rst_valid", out_valid, 0);
      check("rst_row", out_row, N - 1);
      check("rst_data", out_data, 0);
      @(negedge clk) rst_n = 1'b1;
      abort = 1'b1;
      step();
      step();
      abort = 1'b0;
      check("idle_abort_busy", busy, 0);

      load_rand(3);
      run_job(3, 7'b0, 0, -1, 1'b0);

      for (int r = 0; r < N; r++)
         for (int kk = 0; kk < 4; kk++) begin
            A[r][kk] = (r == kk) ? 8'd2 : 8'd0;
            B[kk][r] = (r == kk) ? 8'd1 : 8'd0;
         end
      run_job(4, 7'b0, 0, -1, 1'b1);

      load_rand(5);
      run_job(5, 7'b1101001, 7, -1, 1'b0);

      load_rand(6);
      run_job(6, 7'b0, 0, 5, 1'b0);

      load_rand(4);
      run_job(4, 7'b0, 0, -1, 1'b0);

      run_job(0, 7'b0101010, 7, -1, 1'b0);

      load_rand(2);
      push_expected(2);
      start = 1'b1; k_len = 8'd2;
      step();
      start = 1'b0;
      g = 0;
      while (!out_valid && g < 600) begin step(); g++; end
      check("rst_job_drain", out_valid, 1);
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("rst_job_row", out_row, q[0].row);
         check("rst_job_data", out_data, q[0].data);
         void'(q.pop_front());
         step();
      end
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_feed", feed_en, 0);
      check("arst_set", set_reg, 0);
      check("arst_sel", sel_mux, 0);
      check("arst_valid", out_valid, 0);
      check("arst_row", out_row, N - 1);
      check("arst_data", out_data, 0);
      q.delete();
      out_ready = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_busy", busy, 0);
         check("post_rst_done", done, 0);
      end

      load_rand(2);
      run_job(2, 7'b0, 0, -1, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
